// File: rtl/construtor_caminho_pkg.sv
// Shared definitions for the path builder.
// Holds the default node-identifier width, the default path depth and the
// controller state encoding used by construtor_caminho.
package construtor_caminho_pkg;

  localparam int ADDR_WIDTH_DEF = 8;
  localparam int MAX_PATH_DEF   = 64;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LER    = 3'd1,
    ESPERA = 3'd2,
    SAIDA  = 3'd3,
    PRONTO = 3'd4
  } estado_t;

endpackage

// File: rtl/construtor_caminho_pilha.sv
// pilha_caminho: LIFO holding the nodes of the path being built.
// The destination is pushed first, so popping yields the path source first.
// Ports:
//   clk, rst      clock, synchronous active-high reset (clears count only)
//   clr           synchronous clear of the count (contents left as they are)
//   push, din     write din on top (ignored when full)
//   pop           drop the top entry (ignored when empty)
//   top           current top entry, 0 when empty
//   count         number of stored entries
//   full, empty   status flags
// MAX_PATH must be at least 2.
module pilha_caminho
  import construtor_caminho_pkg::*;
#(
  parameter int  ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int  MAX_PATH   = MAX_PATH_DEF,
  localparam int CNT_W      = $clog2(MAX_PATH + 1),
  localparam int IDX_W      = $clog2(MAX_PATH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] din,
  output logic [ADDR_WIDTH-1:0] top,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty
);

  logic [ADDR_WIDTH-1:0] mem_r [MAX_PATH];
  logic [CNT_W-1:0]      count_r;
  logic [IDX_W-1:0]      top_idx_s;

  assign full  = (count_r == CNT_W'(MAX_PATH));
  assign empty = (count_r == {CNT_W{1'b0}});
  assign count = count_r;

  // Low bits minus one also give the right slot when count equals a power of two.
  assign top_idx_s = count_r[IDX_W-1:0] - IDX_W'(1);
  assign top       = empty ? {ADDR_WIDTH{1'b0}} : mem_r[top_idx_s];

  // Storage write; contents are never reset, only the count is.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_r[count_r[IDX_W-1:0]] <= din;
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_r <= {CNT_W{1'b0}};
    end else if (push && !full) begin
      count_r <= count_r + CNT_W'(1);
    end else if (pop && !empty) begin
      count_r <= count_r - CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/construtor_caminho.sv
// construtor_caminho: rebuilds a path by walking a predecessor memory from the
// destination back to the source, stacking nodes, then streams them source
// first.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   construir_in, fonte_in, destino_in  start request and end points
//   pred_rd_out, pred_addr_out, pred_data_in  predecessor memory (1-cycle read)
//   no_out, no_valid_out, no_ready_in  path stream, valid/ready handshake
//   tamanho_out                     node count of the found path, 0 on error
//   caminho_valido_out              1 = path found, 0 = error
//   caminho_pronto_out, lido_in     result ready level / result consumed
module construtor_caminho
  import construtor_caminho_pkg::*;
#(
  parameter int  ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int  MAX_PATH   = MAX_PATH_DEF,
  localparam int CNT_W      = $clog2(MAX_PATH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  construir_in,
  input  logic [ADDR_WIDTH-1:0] fonte_in,
  input  logic [ADDR_WIDTH-1:0] destino_in,
  output logic                  pred_rd_out,
  output logic [ADDR_WIDTH-1:0] pred_addr_out,
  input  logic [ADDR_WIDTH-1:0] pred_data_in,
  output logic [ADDR_WIDTH-1:0] no_out,
  output logic                  no_valid_out,
  input  logic                  no_ready_in,
  output logic [CNT_W-1:0]      tamanho_out,
  output logic                  caminho_valido_out,
  output logic                  caminho_pronto_out,
  input  logic                  lido_in
);

  estado_t               state_r, state_nx;
  logic [ADDR_WIDTH-1:0] cur_r, cur_nx;
  logic [ADDR_WIDTH-1:0] fonte_r, fonte_nx;
  logic [CNT_W-1:0]      tamanho_r, tamanho_nx;
  logic                  valido_r, valido_nx;
  logic                  pred_rd_r, no_valid_r, pronto_r;
  logic [ADDR_WIDTH-1:0] pred_addr_r;

  logic                  push_s, pop_s, clr_s;
  logic [ADDR_WIDTH-1:0] din_s, top_s;
  logic [CNT_W-1:0]      count_s;
  logic                  full_s, empty_s;

  pilha_caminho #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MAX_PATH   (MAX_PATH)
  ) u_pilha (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_s),
    .push  (push_s),
    .pop   (pop_s),
    .din   (din_s),
    .top   (top_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // no_valid_r is only set in SAIDA, so pops can never coincide with pushes.
  assign pop_s = no_valid_r && no_ready_in && !empty_s;

  // Next-state and datapath decisions; construir_in/lido_in only matter in IDLE/PRONTO.
  always_comb begin
    state_nx   = state_r;
    cur_nx     = cur_r;
    fonte_nx   = fonte_r;
    tamanho_nx = tamanho_r;
    valido_nx  = valido_r;
    push_s     = 1'b0;
    clr_s      = 1'b0;
    din_s      = pred_data_in;
    case (state_r)
      IDLE: begin
        if (construir_in) begin
          push_s     = 1'b1;
          din_s      = destino_in;
          cur_nx     = destino_in;
          fonte_nx   = fonte_in;
          tamanho_nx = CNT_W'(1);
          valido_nx  = 1'b0;
          state_nx   = (destino_in == fonte_in) ? SAIDA : LER;
        end else begin
          state_nx = IDLE;
        end
      end
      LER: begin
        state_nx = ESPERA;
      end
      ESPERA: begin
        // A node that is its own predecessor marks "unreachable".
        if ((pred_data_in == cur_r) || full_s) begin
          clr_s      = 1'b1;
          tamanho_nx = {CNT_W{1'b0}};
          valido_nx  = 1'b0;
          state_nx   = PRONTO;
        end else begin
          push_s     = 1'b1;
          cur_nx     = pred_data_in;
          tamanho_nx = tamanho_r + CNT_W'(1);
          state_nx   = (pred_data_in == fonte_r) ? SAIDA : LER;
        end
      end
      SAIDA: begin
        if (pop_s && (count_s == CNT_W'(1))) begin
          valido_nx = 1'b1;
          state_nx  = PRONTO;
        end else begin
          state_nx = SAIDA;
        end
      end
      PRONTO: begin
        if (lido_in) begin
          tamanho_nx = {CNT_W{1'b0}};
          valido_nx  = 1'b0;
          state_nx   = IDLE;
        end else begin
          state_nx = PRONTO;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; outputs are decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cur_r       <= {ADDR_WIDTH{1'b0}};
      fonte_r     <= {ADDR_WIDTH{1'b0}};
      tamanho_r   <= {CNT_W{1'b0}};
      valido_r    <= 1'b0;
      pred_rd_r   <= 1'b0;
      pred_addr_r <= {ADDR_WIDTH{1'b0}};
      no_valid_r  <= 1'b0;
      pronto_r    <= 1'b0;
    end else begin
      state_r     <= state_nx;
      cur_r       <= cur_nx;
      fonte_r     <= fonte_nx;
      tamanho_r   <= tamanho_nx;
      valido_r    <= valido_nx;
      pred_rd_r   <= (state_nx == LER);
      pred_addr_r <= (state_nx == LER) ? cur_nx : {ADDR_WIDTH{1'b0}};
      no_valid_r  <= (state_nx == SAIDA);
      pronto_r    <= (state_nx == PRONTO);
    end
  end

  assign pred_rd_out        = pred_rd_r;
  assign pred_addr_out      = pred_addr_r;
  assign no_valid_out       = no_valid_r;
  assign no_out             = no_valid_r ? top_s : {ADDR_WIDTH{1'b0}};
  assign tamanho_out        = tamanho_r;
  assign caminho_valido_out = valido_r;
  assign caminho_pronto_out = pronto_r;

endmodule

// File: doc/construtor_caminho.md
CONSTRUTOR_CAMINHO -- requirements
Module: construtor_caminho

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, node identifier width.
REQ-002 Parameter MAX_PATH, default 64, stack depth (max nodes in one path); CNT_W = clog2(MAX_PATH+1).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 construir_in  in  1  start request (level), driven by top controller's build-path output.
REQ-006 fonte_in  in  ADDR_WIDTH  source node, sampled at start.
REQ-007 destino_in  in  ADDR_WIDTH  destination node, sampled at start.
REQ-008 pred_rd_out  out  1  predecessor-memory read strobe.
REQ-009 pred_addr_out  out  ADDR_WIDTH  predecessor-memory read address.
REQ-010 pred_data_in  in  ADDR_WIDTH  predecessor of addressed node, valid exactly 1 cycle after pred_rd_out.
REQ-011 no_out / no_valid_out / no_ready_in  out ADDR_WIDTH / out 1 / in 1  path stream, source first.
REQ-012 tamanho_out  out  CNT_W  number of nodes in found path; 0 on error.
REQ-013 caminho_valido_out  out  1  path found (1) or error (0); meaningful while caminho_pronto_out=1.
REQ-014 caminho_pronto_out  out  1  build finished, level, held until lido_in.
REQ-015 lido_in  in  1  result consumed; returns block to idle.

Function
REQ-016 States SHALL be IDLE, LER, ESPERA, SAIDA, PRONTO.
REQ-017 IDLE with construir_in=1: register fonte/destino, push destino (count=1), cur=destino, tamanho=1; if destino==fonte go SAIDA, else LER.
REQ-018 LER: pred_rd_out=1, pred_addr_out=cur for exactly one cycle; next ESPERA.
REQ-019 ESPERA, pred_data_in==cur (unreachable marker): go PRONTO, caminho_valido_out=0, tamanho_out=0, stack cleared.
REQ-020 ESPERA, count==MAX_PATH (no room): go PRONTO as error, same as REQ-019.
REQ-021 ESPERA otherwise: push pred_data_in, cur=pred_data_in, count+1; if pred_data_in==fonte go SAIDA, else LER (2 cycles per hop).
REQ-022 SAIDA: no_valid_out=1, no_out=top of stack; pop on no_valid_out&&no_ready_in; after last pop go PRONTO with caminho_valido_out=1.
REQ-023 no_out SHALL hold stable while no_valid_out=1 and no_ready_in=0.
REQ-024 PRONTO: caminho_pronto_out=1; lido_in=1 -> IDLE next cycle; otherwise hold.
REQ-025 construir_in outside IDLE SHALL be ignored; lido_in outside PRONTO SHALL be ignored.
REQ-026 tamanho_out SHALL equal pushed-node count (source and destination inclusive) from start through PRONTO on success.
REQ-027 pred_rd_out SHALL be 0 in every state except LER.
REQ-028 Push and pop never coincide (disjoint states); count never exceeds MAX_PATH nor goes below 0.

Reset
REQ-029 rst=1 at any clock edge, including mid-build or mid-stream: state IDLE, count 0, all outputs 0 on following cycle.
REQ-030 Stack storage contents need not be reset; only count/pointer.

Structure
REQ-031 State encoding constants and ADDR_WIDTH/MAX_PATH defaults SHALL live in the shared project package.
REQ-032 LIFO SHALL be one sub-module, pilha_caminho (push, pop, top, count, full, empty), parameterised by ADDR_WIDTH and MAX_PATH.
REQ-033 Controller FSM and datapath (cur, fonte, destino registers) SHALL reside in construtor_caminho.

Verification
REQ-034 fonte=2, destino=9, pred[9]=5, pred[5]=2, no_ready_in=1 -> two reads (addr 9, 5), stream 2,5,9, tamanho_out=3, valido=1, pronto held until lido_in.
REQ-035 fonte=destino=4 -> no reads, stream 4, tamanho_out=1, valido=1.
REQ-036 fonte=1, destino=7, pred[7]=3, pred[3]=3 -> PRONTO, valido=0, tamanho_out=0, no_valid_out never asserted.
REQ-037 MAX_PATH=4, chain of 5 nodes -> error at 4th ESPERA, valido=0, tamanho_out=0.
REQ-038 REQ-034 stimulus with no_ready_in toggling 1/0 each cycle -> same sequence 2,5,9, no_out stable while stalled, no drops or duplicates.
REQ-039 rst asserted in ESPERA and again in SAIDA -> IDLE, all outputs 0 next cycle; fresh construir_in builds correct path.
